ilb_window_feeder: RTL and testbench

Input line buffer for the SoPU datapath. It accepts a raster pixel stream, stores two image lines, and emits 2×3 byte windows to the downstream line-buffer interface stage. That stage leaves IDLE on `ilb_read_enable`, waits for `sop_to_ilb_rts`, then latches the six bytes over two cycles while pulsing `bytes_recieved`. This block sits directly upstream of that stage and drives exactly that handshake.

---
 rtl/sopu_ilb_pkg.sv | 29 ++
 rtl/ilb_window_feeder_if.sv | 31 +++
 rtl/ilb_line_mem.sv | 31 +++
 rtl/ilb_window_feeder.sv | 188 ++++++++++++++++++
 tb/tb_ilb_window_feeder.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sopu_ilb_pkg.sv
// Shared constants and state encoding for the SoPU input line buffer.
package sopu_ilb_pkg;

    localparam int BYTE_W   = 8;
    localparam int WIN_ROWS = 2;
    localparam int WIN_COLS = 3;

    localparam logic [2:0] ST_FILL_TOP = 3'd0;
    localparam logic [2:0] ST_FILL_BOT = 3'd1;
    localparam logic [2:0] ST_LOAD     = 3'd2;
    localparam logic [2:0] ST_OFFER    = 3'd3;
    localparam logic [2:0] ST_RELEASE  = 3'd4;
    localparam logic [2:0] ST_ADVANCE  = 3'd5;

    typedef enum logic [2:0] {
        FILL_TOP = ST_FILL_TOP,
        FILL_BOT = ST_FILL_BOT,
        LOAD     = ST_LOAD,
        OFFER    = ST_OFFER,
        RELEASE  = ST_RELEASE,
        ADVANCE  = ST_ADVANCE
    } ilb_state_e;

    // Counter width for a 0..n-1 range, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ilb_window_feeder_if.sv
// Pixel stream input plus the window handshake towards the line-buffer interface stage.
interface ilb_window_feeder_if;
    import sopu_ilb_pkg::*;

    logic [BYTE_W-1:0] pix_in;
    logic              pix_valid;
    logic              pix_ready;
    logic              ilb_read_enable;
    logic              sop_to_ilb_rts;
    logic              bytes_recieved;
    logic [BYTE_W-1:0] ilb_byte_0;
    logic [BYTE_W-1:0] ilb_byte_1;
    logic [BYTE_W-1:0] ilb_byte_2;
    logic [BYTE_W-1:0] ilb_byte_3;
    logic [BYTE_W-1:0] ilb_byte_4;
    logic [BYTE_W-1:0] ilb_byte_5;
    logic              frame_done;

    modport master (
        input  pix_in, pix_valid, bytes_recieved,
        output pix_ready, ilb_read_enable, sop_to_ilb_rts, frame_done,
        output ilb_byte_0, ilb_byte_1, ilb_byte_2, ilb_byte_3, ilb_byte_4, ilb_byte_5
    );

    modport slave (
        output pix_in, pix_valid, bytes_recieved,
        input  pix_ready, ilb_read_enable, sop_to_ilb_rts, frame_done,
        input  ilb_byte_0, ilb_byte_1, ilb_byte_2, ilb_byte_3, ilb_byte_4, ilb_byte_5
    );

endinterface

// File: rtl/ilb_line_mem.sv
// One image line of storage: a synchronous write port and three adjacent combinational read taps.
module ilb_line_mem
    import sopu_ilb_pkg::*;
#(
    parameter int IMG_WIDTH = 8,
    parameter int AW        = cnt_width(IMG_WIDTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [BYTE_W-1:0] wr_data_i,
    input  logic [AW-1:0]     col_i,
    output logic [BYTE_W-1:0] tap0_o,
    output logic [BYTE_W-1:0] tap1_o,
    output logic [BYTE_W-1:0] tap2_o
);

    logic [BYTE_W-1:0] mem_q [IMG_WIDTH];

    // Line storage write; contents are don't-care after reset so no reset term.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign tap0_o = mem_q[col_i];
    assign tap1_o = mem_q[col_i + AW'(1)];
    assign tap2_o = mem_q[col_i + AW'(2)];

endmodule

// File: rtl/ilb_window_feeder.sv
// Two-line buffer that turns a raster pixel stream into 2x3 byte windows and offers
// each one to the downstream stage with an rts / bytes_recieved handshake.
module ilb_window_feeder
    import sopu_ilb_pkg::*;
#(
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8
) (
    input  logic                clk,
    input  logic                rst,
    ilb_window_feeder_if.master bus
);

    localparam int CW = cnt_width(IMG_WIDTH);
    localparam int RW = cnt_width(IMG_HEIGHT - 1);
    localparam int NB = WIN_ROWS * WIN_COLS;
    localparam logic [CW-1:0] WR_LAST  = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] RD_LAST  = CW'(IMG_WIDTH - 3);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 2);

    ilb_state_e        state_q, state_d;
    logic [CW-1:0]     wr_col_q, wr_col_d;
    logic [CW-1:0]     rd_col_q, rd_col_d;
    logic [RW-1:0]     row_pair_q, row_pair_d;
    logic              top_sel_q, top_sel_d;
    logic              pix_ready_q, rts_q;
    logic              frame_done_q, frame_done_d;
    logic [BYTE_W-1:0] win_q [NB];
    logic [BYTE_W-1:0] win_d [NB];

    logic              fill_s, xfer_s, wr_line_s, load_s;
    logic [BYTE_W-1:0] l0_tap_s  [WIN_COLS];
    logic [BYTE_W-1:0] l1_tap_s  [WIN_COLS];
    logic [BYTE_W-1:0] top_tap_s [WIN_COLS];
    logic [BYTE_W-1:0] bot_tap_s [WIN_COLS];

    assign fill_s    = (state_q == FILL_TOP) || (state_q == FILL_BOT);
    assign xfer_s    = bus.pix_valid & pix_ready_q & fill_s;
    // FILL_TOP writes the top line, FILL_BOT the other one.
    assign wr_line_s = (state_q == FILL_TOP) ? top_sel_q : ~top_sel_q;

    ilb_line_mem #(.IMG_WIDTH(IMG_WIDTH), .AW(CW)) u_line0 (
        .clk       (clk),
        .we_i      (xfer_s & ~wr_line_s),
        .wr_addr_i (wr_col_q),
        .wr_data_i (bus.pix_in),
        .col_i     (rd_col_q),
        .tap0_o    (l0_tap_s[0]),
        .tap1_o    (l0_tap_s[1]),
        .tap2_o    (l0_tap_s[2])
    );

    ilb_line_mem #(.IMG_WIDTH(IMG_WIDTH), .AW(CW)) u_line1 (
        .clk       (clk),
        .we_i      (xfer_s & wr_line_s),
        .wr_addr_i (wr_col_q),
        .wr_data_i (bus.pix_in),
        .col_i     (rd_col_q),
        .tap0_o    (l1_tap_s[0]),
        .tap1_o    (l1_tap_s[1]),
        .tap2_o    (l1_tap_s[2])
    );

    // Route taps to window rows by top_sel and stage the next window contents.
    always_comb begin
        for (int i = 0; i < WIN_COLS; i++) begin
            top_tap_s[i]        = top_sel_q ? l1_tap_s[i] : l0_tap_s[i];
            bot_tap_s[i]        = top_sel_q ? l0_tap_s[i] : l1_tap_s[i];
            win_d[i]            = load_s ? top_tap_s[i] : win_q[i];
            win_d[WIN_COLS + i] = load_s ? bot_tap_s[i] : win_q[WIN_COLS + i];
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_d      = state_q;
        wr_col_d     = wr_col_q;
        rd_col_d     = rd_col_q;
        row_pair_d   = row_pair_q;
        top_sel_d    = top_sel_q;
        frame_done_d = 1'b0;
        load_s       = 1'b0;
        case (state_q)
            FILL_TOP, FILL_BOT: begin
                if (xfer_s && (wr_col_q == WR_LAST)) begin
                    wr_col_d = {CW{1'b0}};
                    state_d  = (state_q == FILL_TOP) ? FILL_BOT : LOAD;
                end else if (xfer_s) begin
                    wr_col_d = wr_col_q + CW'(1);
                end else begin
                    wr_col_d = wr_col_q;
                end
            end
            LOAD: begin
                load_s  = 1'b1;
                state_d = OFFER;
            end
            OFFER: begin
                if (bus.bytes_recieved) begin
                    state_d = RELEASE;
                end else begin
                    state_d = OFFER;
                end
            end
            RELEASE: begin
                if (!bus.bytes_recieved) begin
                    state_d = ADVANCE;
                end else begin
                    state_d = RELEASE;
                end
            end
            ADVANCE: begin
                if (rd_col_q < RD_LAST) begin
                    rd_col_d = rd_col_q + CW'(1);
                    state_d  = LOAD;
                end else if (row_pair_q < ROW_LAST) begin
                    // The retiring top line becomes the new bottom and is refilled.
                    rd_col_d   = {CW{1'b0}};
                    row_pair_d = row_pair_q + RW'(1);
                    top_sel_d  = ~top_sel_q;
                    state_d    = FILL_BOT;
                end else begin
                    rd_col_d     = {CW{1'b0}};
                    row_pair_d   = {RW{1'b0}};
                    wr_col_d     = {CW{1'b0}};
                    top_sel_d    = 1'b0;
                    frame_done_d = 1'b1;
                    state_d      = FILL_TOP;
                end
            end
            default: begin
                state_d    = FILL_TOP;
                wr_col_d   = {CW{1'b0}};
                rd_col_d   = {CW{1'b0}};
                row_pair_d = {RW{1'b0}};
                top_sel_d  = 1'b0;
            end
        endcase
    end

    // State, counters and handshake outputs; outputs are registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FILL_TOP;
            wr_col_q     <= {CW{1'b0}};
            rd_col_q     <= {CW{1'b0}};
            row_pair_q   <= {RW{1'b0}};
            top_sel_q    <= 1'b0;
            pix_ready_q  <= 1'b0;
            rts_q        <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_col_q     <= wr_col_d;
            rd_col_q     <= rd_col_d;
            row_pair_q   <= row_pair_d;
            top_sel_q    <= top_sel_d;
            pix_ready_q  <= (state_d == FILL_TOP) || (state_d == FILL_BOT);
            rts_q        <= (state_d == OFFER);
            frame_done_q <= frame_done_d;
        end
    end

    // Window byte registers: change only in LOAD, hold through the handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NB; i++) begin
                win_q[i] <= {BYTE_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NB; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

    assign bus.pix_ready       = pix_ready_q;
    assign bus.sop_to_ilb_rts  = rts_q;
    assign bus.ilb_read_enable = rts_q;
    assign bus.frame_done      = frame_done_q;
    assign bus.ilb_byte_0      = win_q[0];
    assign bus.ilb_byte_1      = win_q[1];
    assign bus.ilb_byte_2      = win_q[2];
    assign bus.ilb_byte_3      = win_q[3];
    assign bus.ilb_byte_4      = win_q[4];
    assign bus.ilb_byte_5      = win_q[5];

endmodule

// File: tb/tb_ilb_window_feeder.sv
// Randomised bench for ilb_window_feeder: pixel driver, consumer model and a
// window-index based reference that predicts every offered window.
module tb_ilb_window_feeder;

    localparam int W   = 4;
    localparam int H   = 3;
    localparam int WPF = (H - 1) * (W - 2);
    localparam int PPF = W * H;

    logic clk;
    logic rst;
    ilb_window_feeder_if bus ();

    ilb_window_feeder #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    int gp = 0;              // pixels accepted (driver)
    int gw = 0;              // windows acknowledged (consumer)
    int fd_cnt = 0;          // frame_done pulses seen (monitor)
    int pix_target = 0;
    int gap_pct = 0;
    int ack_limit = 1 << 30;
    int delay_win = -1;
    int spur_cnt = 0;
    int spur_done = 0;
    bit latching = 1'b0;
    logic [47:0] got [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] pv(input int r, input int c);
        return 8'((r * 16 + c) & 255);
    endfunction

    // Expected window for acknowledgement index w, from row/column arithmetic.
    function automatic logic [47:0] exp_win(input int w);
        int k, rp, c;
        k  = w % WPF;
        rp = k / (W - 2);
        c  = k % (W - 2);
        return {pv(rp, c), pv(rp, c + 1), pv(rp, c + 2),
                pv(rp + 1, c), pv(rp + 1, c + 1), pv(rp + 1, c + 2)};
    endfunction

    // Windows that must be consumed before pixel p may be accepted.
    function automatic int req_win(input int p);
        int f, r;
        f = p / PPF;
        r = (p % PPF) / W;
        return f * WPF + ((r >= 2) ? (r - 1) * (W - 2) : 0);
    endfunction

    // Pixels that must have arrived before window w may be offered.
    function automatic int req_pix(input int w);
        int f, rp;
        f  = w / WPF;
        rp = (w % WPF) / (W - 2);
        return f * PPF + (rp + 2) * W;
    endfunction

    function automatic logic [47:0] lit_win(input int i);
        case (i)
            0:       return {8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12};
            1:       return {8'h01, 8'h02, 8'h03, 8'h11, 8'h12, 8'h13};
            2:       return {8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22};
            3:       return {8'h11, 8'h12, 8'h13, 8'h21, 8'h22, 8'h23};
            default: return 48'h0;
        endcase
    endfunction

    function automatic logic [47:0] cur_bytes();
        return {bus.ilb_byte_0, bus.ilb_byte_1, bus.ilb_byte_2,
                bus.ilb_byte_3, bus.ilb_byte_4, bus.ilb_byte_5};
    endfunction

    // Pixel driver
    initial begin
        bit pend;
        pend = 1'b0;
        bus.pix_valid = 1'b0;
        bus.pix_in = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                gp = 0;
                pend = 1'b0;
                bus.pix_valid = 1'b0;
            end else begin
                if (pend) gp++;
                pend = 1'b0;
                if (gp < pix_target) begin
                    bus.pix_valid = ($urandom_range(99, 0) >= gap_pct);
                    bus.pix_in = pv((gp % PPF) / W, gp % W);
                end else begin
                    bus.pix_valid = 1'b0;
                    bus.pix_in = 8'($urandom_range(255, 0));
                end
                pend = bus.pix_valid && bus.pix_ready;
            end
        end
    end

    // Consumer model: IDLE -> WAIT for rts -> two latch cycles with bytes_recieved high
    initial begin
        int dly;
        bus.bytes_recieved = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                gw = 0;
                latching = 1'b0;
                bus.bytes_recieved = 1'b0;
            end else if (spur_done != spur_cnt) begin
                bus.bytes_recieved = 1'b1;
                @(posedge clk); #1;
                @(posedge clk); #1;
                bus.bytes_recieved = 1'b0;
                spur_done++;
            end else if (bus.sop_to_ilb_rts && (gw < ack_limit)) begin
                dly = (gw == delay_win) ? 20 : 0;
                for (int d = 0; d < dly; d++) begin
                    @(posedge clk); #1;
                    chk("rts_held", bus.sop_to_ilb_rts, 1);
                end
                bus.bytes_recieved = 1'b1;
                latching = 1'b1;
                got.push_back(cur_bytes());
                @(posedge clk); #1;
                @(posedge clk); #1;
                bus.bytes_recieved = 1'b0;
                latching = 1'b0;
                gw++;
            end
        end
    end

    // Compare process: checks the DUT against the reference on every cycle
    initial begin
        bit prev_rts;
        prev_rts = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_rts = 1'b0;
                fd_cnt = 0;
            end else begin
                chk("re_eq_rts", bus.ilb_read_enable, bus.sop_to_ilb_rts);
                if (bus.pix_ready) begin
                    chk("ready_vs_rts", bus.sop_to_ilb_rts, 0);
                    chk("ready_allowed", gw >= req_win(gp), 1);
                end
                if (bus.sop_to_ilb_rts) chk("rts_rows_present", gp >= req_pix(gw), 1);
                if (bus.sop_to_ilb_rts || latching) chk("window", cur_bytes(), exp_win(gw));
                if (prev_rts && !bus.sop_to_ilb_rts) chk("rts_drop_acked", latching, 1);
                if (bus.frame_done) begin
                    chk("fd_at_frame_end", gw, (fd_cnt + 1) * WPF);
                    fd_cnt++;
                end
                prev_rts = bus.sop_to_ilb_rts;
            end
        end
    end

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_pix_ready"}, bus.pix_ready, 0);
        chk({tag, "_rts"}, bus.sop_to_ilb_rts, 0);
        chk({tag, "_read_enable"}, bus.ilb_read_enable, 0);
        chk({tag, "_frame_done"}, bus.frame_done, 0);
        chk({tag, "_bytes"}, cur_bytes(), 48'h0);
    endtask

    task automatic wait_done(input string tag, input int wins, input int fds);
        int n;
        n = 0;
        while (!((gw >= wins) && (fd_cnt >= fds)) && (n < 3000)) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_timeout"}, n < 3000, 1);
        repeat (10) @(negedge clk);
        chk({tag, "_windows"}, gw, wins);
        chk({tag, "_frame_done_cnt"}, fd_cnt, fds);
    endtask

    initial begin
        int n, base;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_reset", bus.pix_ready, 1);

        // Full frame, no gaps
        pix_target = PPF;
        wait_done("frame1", WPF, 1);
        chk("frame1_count", got.size(), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("frame1_win%0d", i), got[i], lit_win(i));

        // Two more frames with ~50% gaps, a spurious ack in FILL_BOT and a 20-cycle stall
        gap_pct = 50;
        delay_win = 5;
        pix_target = PPF + 6;
        n = 0;
        while ((gp < PPF + 6) && (n < 1000)) begin @(negedge clk); n++; end
        chk("fill_bot_timeout", n < 1000, 1);
        spur_cnt++;
        n = 0;
        while ((spur_done != spur_cnt) && (n < 100)) begin @(negedge clk); n++; end
        chk("spur_timeout", n < 100, 1);
        chk("spur_ignored_ready", bus.pix_ready, 1);
        chk("spur_ignored_rts", bus.sop_to_ilb_rts, 0);
        pix_target = 3 * PPF;
        wait_done("frames23", 3 * WPF, 3);
        chk("frames23_count", got.size(), 12);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("frame2_win%0d", i), got[4 + i], lit_win(i));
            chk($sformatf("frame3_win%0d", i), got[8 + i], lit_win(i));
        end

        // Reset while the second window of a frame is in OFFER
        gap_pct = 0;
        delay_win = -1;
        ack_limit = 3 * WPF + 1;
        pix_target = 4 * PPF;
        n = 0;
        while (!(bus.sop_to_ilb_rts && (gw == 3 * WPF + 1)) && (n < 1000)) begin
            @(negedge clk);
            n++;
        end
        chk("offer_timeout", n < 1000, 1);
        rst = 1'b1;
        pix_target = 0;
        ack_limit = 1 << 30;
        @(posedge clk); #1;
        chk_zero_outputs("midrst");
        base = got.size();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_midrst", bus.pix_ready, 1);
        pix_target = PPF;
        wait_done("postrst", WPF, 1);
        chk("postrst_count", got.size(), base + 4);
        for (int i = 0; i < 4; i++) chk($sformatf("postrst_win%0d", i), got[base + i], lit_win(i));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
